// File: rtl/cp0_irq.sv
// CP0 subset: Count/Compare timer, Status/Cause/EPC, interrupt request and a
// shadow stack of {Status, EPC} so nested exceptions unwind with eret.
module cp0_irq #(
  parameter int          NUM_IRQ    = 6,
  parameter int          NEST_DEPTH = 3,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mfc0,
  input  logic               mtc0,
  input  logic [4:0]         addr,
  input  logic [31:0]        wdata,
  input  logic [31:0]        pc,
  input  logic               exception,
  input  logic               eret,
  input  logic [4:0]         cause,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic [31:0]        exc_addr,
  output logic               irq_req,
  output logic               nest_overflow
);

  localparam int DW = $clog2(NEST_DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(NEST_DEPTH);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;

  logic [31:0]        count, compare, status, epc;
  logic [4:0]         exc_code;
  logic [NUM_IRQ-1:0] ip, ip_next;
  logic               ti;
  logic [DW-1:0]      depth;
  logic [31:0]        stk_status [NEST_DEPTH];
  logic [31:0]        stk_epc    [NEST_DEPTH];

  logic        entry, wr_en;
  logic [31:0] cause_reg, top_status, top_epc;

  // eret wins over exception, and either one discards a same-cycle mtc0.
  assign entry = exception & ~eret;
  assign wr_en = mtc0 & ~exception & ~eret;

  always_comb begin
    cause_reg               = '0;
    cause_reg[6:2]          = exc_code;
    cause_reg[8 +: NUM_IRQ] = ip;
    cause_reg[30]           = ti;
  end

  always_comb begin
    ip_next              = irq;
    ip_next[NUM_IRQ-1]   = irq[NUM_IRQ-1] | ti;
  end

  // Entry 0 is the oldest frame; the top sits at depth-1.
  always_comb begin
    top_status = '0;
    top_epc    = '0;
    for (int i = 0; i < NEST_DEPTH; i++) begin
      if (DW'(i) == depth - DW'(1)) begin
        top_status = stk_status[i];
        top_epc    = stk_epc[i];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (mfc0) begin
      case (addr)
        REG_COUNT:   rdata = count;
        REG_COMPARE: rdata = compare;
        REG_STATUS:  rdata = status;
        REG_CAUSE:   rdata = cause_reg;
        REG_EPC:     rdata = epc;
        default:     rdata = '0;
      endcase
    end
  end

  assign exc_addr = eret ? epc : EXC_VECTOR;
  assign irq_req  = ~rst & status[0] & (|(ip & status[8 +: NUM_IRQ]));

  always_ff @(posedge clk) begin
    if (rst) begin
      count         <= '0;
      compare       <= '0;
      status        <= '0;
      epc           <= '0;
      exc_code      <= '0;
      ip            <= '0;
      ti            <= 1'b0;
      depth         <= '0;
      nest_overflow <= 1'b0;
      for (int i = 0; i < NEST_DEPTH; i++) begin
        stk_status[i] <= '0;
        stk_epc[i]    <= '0;
      end
    end else begin
      ip    <= ip_next;
      count <= (wr_en && addr == REG_COUNT) ? wdata : count + 32'd1;

      if (wr_en && addr == REG_COMPARE)
        ti <= 1'b0;
      else if (count == compare)
        ti <= 1'b1;

      if (eret) begin
        if (depth != '0) begin
          status <= top_status;
          epc    <= top_epc;
          depth  <= depth - DW'(1);
        end
      end else if (entry) begin
        // A full stack slides down, losing the oldest frame, so the newest
        // NEST_DEPTH levels always unwind correctly.
        if (depth == FULL) begin
          for (int i = 0; i < NEST_DEPTH - 1; i++) begin
            stk_status[i] <= stk_status[i+1];
            stk_epc[i]    <= stk_epc[i+1];
          end
          stk_status[NEST_DEPTH-1] <= status;
          stk_epc[NEST_DEPTH-1]    <= epc;
          nest_overflow            <= 1'b1;
        end else begin
          for (int i = 0; i < NEST_DEPTH; i++) begin
            if (DW'(i) == depth) begin
              stk_status[i] <= status;
              stk_epc[i]    <= epc;
            end
          end
          depth <= depth + DW'(1);
        end
        epc      <= pc;
        exc_code <= cause;
        status   <= {status[31:1], 1'b0};
      end else if (wr_en) begin
        case (addr)
          REG_COMPARE: compare  <= wdata;
          REG_STATUS:  status   <= wdata;
          REG_CAUSE:   exc_code <= wdata[6:2];
          REG_EPC:     epc      <= wdata;
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp0_irq.sv
// Directed bench for cp0_irq: interrupt entry, nesting/overflow, timer,
// strobe priorities and reset, with hand-computed expected values.
module tb_cp0_irq;

  logic        clk = 1'b0;
  logic        rst;
  logic        mfc0, mtc0, exception, eret;
  logic [4:0]  addr, cause;
  logic [31:0] wdata, pc, rdata, exc_addr;
  logic [5:0]  irq;
  logic        irq_req, nest_overflow;

  int checks   = 0;
  int failures = 0;

  cp0_irq #(.NUM_IRQ(6), .NEST_DEPTH(3), .EXC_VECTOR(32'h0040_0004)) dut (
    .clk(clk), .rst(rst), .mfc0(mfc0), .mtc0(mtc0), .addr(addr),
    .wdata(wdata), .pc(pc), .exception(exception), .eret(eret),
    .cause(cause), .irq(irq), .rdata(rdata), .exc_addr(exc_addr),
    .irq_req(irq_req), .nest_overflow(nest_overflow)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    mtc0 = 1'b0; mfc0 = 1'b0; exception = 1'b0; eret = 1'b0;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    mtc0 = 1'b1; addr = a; wdata = d;
    tick();
  endtask

  task automatic read_check(input string tag, input logic [4:0] a, input logic [31:0] expected);
    mfc0 = 1'b1; addr = a;
    #1;
    check(tag, rdata, expected);
    mfc0 = 1'b0;
  endtask

  task automatic enter(input logic [31:0] p, input logic [4:0] c);
    exception = 1'b1; pc = p; cause = c;
    tick();
  endtask

  task automatic leave_check(input string tag, input logic [31:0] expected_addr);
    eret = 1'b1;
    #1;
    check(tag, exc_addr, expected_addr);
    tick();
  endtask

  initial begin
    rst = 1'b1; mfc0 = 0; mtc0 = 0; exception = 0; eret = 0;
    addr = '0; cause = '0; wdata = '0; pc = '0; irq = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_irq_req", {31'b0, irq_req}, 32'd0);
    check("rst_exc_addr", exc_addr, 32'h0040_0004);
    check("rst_overflow", {31'b0, nest_overflow}, 32'd0);
    read_check("rst_status", 5'd12, 32'd0);
    read_check("rst_epc", 5'd14, 32'd0);
    read_check("rst_cause", 5'd13, 32'd0);
    read_check("rst_count", 5'd9, 32'd0);

    // Park Compare far away so the timer stays quiet for now
    write_reg(5'd11, 32'hFFFF_0000);

    // Interrupt taken as an exception with cause 0
    write_reg(5'd12, 32'h0000_0101);
    read_check("status_wr", 5'd12, 32'h0000_0101);
    irq = 6'b000001;
    tick();
    irq = 6'b000000;
    read_check("cause_ip0", 5'd13, 32'h0000_0100);
    check("irq_req_on", {31'b0, irq_req}, 32'd1);
    exception = 1'b1; pc = 32'h100; cause = 5'd0;
    #1;
    check("exc_vector", exc_addr, 32'h0040_0004);
    tick();
    read_check("int_epc", 5'd14, 32'h100);
    read_check("int_status", 5'd12, 32'h100);
    check("int_irq_req_off", {31'b0, irq_req}, 32'd0);
    leave_check("int_eret_addr", 32'h100);
    read_check("int_restore_status", 5'd12, 32'h101);
    read_check("int_restore_epc", 5'd14, 32'h0);

    // Unmapped register, mfc0 low, Cause write mask
    write_reg(5'd5, 32'hDEAD_BEEF);
    read_check("unmapped_rd", 5'd5, 32'd0);
    addr = 5'd12; mfc0 = 1'b0;
    #1;
    check("rdata_no_mfc0", rdata, 32'd0);
    write_reg(5'd13, 32'hFFFF_FFFF);
    read_check("cause_wr_mask", 5'd13, 32'h0000_007C);

    // Three nested entries and unwinding
    write_reg(5'd14, 32'h0);
    enter(32'h10, 5'd1);
    write_reg(5'd12, 32'h203);
    enter(32'h20, 5'd2);
    write_reg(5'd12, 32'h305);
    enter(32'h30, 5'd3);
    read_check("nest3_epc", 5'd14, 32'h30);
    read_check("nest3_cause", 5'd13, 32'h0000_000C);
    read_check("nest3_status", 5'd12, 32'h304);
    check("nest3_no_ovf", {31'b0, nest_overflow}, 32'd0);
    leave_check("pop1_addr", 32'h30);
    read_check("pop1_status", 5'd12, 32'h305);
    read_check("pop1_epc", 5'd14, 32'h20);
    leave_check("pop2_addr", 32'h20);
    read_check("pop2_status", 5'd12, 32'h203);
    read_check("pop2_epc", 5'd14, 32'h10);
    leave_check("pop3_addr", 32'h10);
    read_check("pop3_status", 5'd12, 32'h101);
    read_check("pop3_epc", 5'd14, 32'h0);
    write_reg(5'd14, 32'h77);
    leave_check("empty_eret_addr", 32'h77);
    read_check("empty_eret_status", 5'd12, 32'h101);
    read_check("empty_eret_epc", 5'd14, 32'h77);

    // Four entries into a three-deep stack
    enter(32'hA0, 5'd4);
    write_reg(5'd12, 32'h111);
    enter(32'hB0, 5'd5);
    write_reg(5'd12, 32'h121);
    enter(32'hC0, 5'd6);
    check("full_no_ovf", {31'b0, nest_overflow}, 32'd0);
    write_reg(5'd12, 32'h131);
    enter(32'hD0, 5'd8);
    check("ovf_set", {31'b0, nest_overflow}, 32'd1);
    read_check("ovf_epc", 5'd14, 32'hD0);
    read_check("ovf_status", 5'd12, 32'h130);
    read_check("ovf_cause", 5'd13, 32'h0000_0020);
    leave_check("ovf_pop1_addr", 32'hD0);
    read_check("ovf_pop1_status", 5'd12, 32'h131);
    leave_check("ovf_pop2_addr", 32'hC0);
    read_check("ovf_pop2_status", 5'd12, 32'h121);
    leave_check("ovf_pop3_addr", 32'hB0);
    read_check("ovf_pop3_status", 5'd12, 32'h111);
    read_check("ovf_pop3_epc", 5'd14, 32'hA0);
    leave_check("ovf_pop4_addr", 32'hA0);
    read_check("ovf_pop4_status", 5'd12, 32'h111);
    read_check("ovf_pop4_epc", 5'd14, 32'hA0);
    check("ovf_sticky", {31'b0, nest_overflow}, 32'd1);

    // Strobe priorities
    mtc0 = 1'b1; addr = 5'd14; wdata = 32'h44;
    exception = 1'b1; pc = 32'h200; cause = 5'd7;
    tick();
    read_check("exc_beats_mtc0", 5'd14, 32'h200);
    exception = 1'b1; eret = 1'b1; pc = 32'h300; cause = 5'd9;
    #1;
    check("exc_eret_addr", exc_addr, 32'h200);
    tick();
    read_check("exc_eret_epc", 5'd14, 32'hA0);
    read_check("exc_eret_status", 5'd12, 32'h111);
    read_check("exc_eret_cause", 5'd13, 32'h0000_001C);
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'h0000_FFFF; eret = 1'b1;
    tick();
    read_check("eret_beats_mtc0", 5'd12, 32'h111);

    // Timer: Count=5 then Compare=8
    write_reg(5'd9, 32'd5);
    write_reg(5'd11, 32'd8);
    read_check("cnt_after_cmp_wr", 5'd9, 32'd6);
    read_check("ti_clear_early", 5'd13, 32'h0000_001C);
    tick();
    tick();
    read_check("cnt_eq_cmp", 5'd9, 32'd8);
    read_check("ti_not_yet", 5'd13, 32'h0000_001C);
    tick();
    read_check("ti_set", 5'd13, 32'h4000_001C);
    tick();
    read_check("ti_ip5", 5'd13, 32'h4000_201C);
    write_reg(5'd12, 32'h0000_2001);
    check("timer_irq_req", {31'b0, irq_req}, 32'd1);
    write_reg(5'd11, 32'h100);
    read_check("ti_cleared", 5'd13, 32'h0000_201C);
    tick();
    read_check("ip5_cleared", 5'd13, 32'h0000_001C);
    check("timer_irq_req_off", {31'b0, irq_req}, 32'd0);
    write_reg(5'd9, 32'hFFFF_FFFF);
    read_check("cnt_max", 5'd9, 32'hFFFF_FFFF);
    tick();
    read_check("cnt_wrap", 5'd9, 32'd0);

    // Reset at depth 2 with irq high and strobes active
    write_reg(5'd12, 32'h101);
    irq = 6'b000001;
    enter(32'h400, 5'd2);
    enter(32'h500, 5'd3);
    write_reg(5'd12, 32'h101);
    check("pre_rst_irq_req", {31'b0, irq_req}, 32'd1);
    rst = 1'b1;
    mtc0 = 1'b1; addr = 5'd12; wdata = 32'hFFFF_FFFF;
    exception = 1'b1; pc = 32'h600; cause = 5'd4;
    tick();
    rst = 1'b0;
    check("mid_rst_irq_req", {31'b0, irq_req}, 32'd0);
    check("mid_rst_overflow", {31'b0, nest_overflow}, 32'd0);
    read_check("mid_rst_status", 5'd12, 32'd0);
    read_check("mid_rst_epc", 5'd14, 32'd0);
    read_check("mid_rst_cause", 5'd13, 32'd0);
    read_check("mid_rst_count", 5'd9, 32'd0);
    read_check("mid_rst_compare", 5'd11, 32'd0);
    write_reg(5'd14, 32'h99);
    leave_check("mid_rst_eret_addr", 32'h99);
    read_check("mid_rst_depth0", 5'd14, 32'h99);
    check("post_rst_irq_req", {31'b0, irq_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
